// File: rtl/prog_loader_if.sv
// Program-loader bus: load request, serial byte stream, instruction-memory
// write port and CPU run/status flags.
//   master : drives start/word_count/byte_in/byte_valid (host side)
//   slave  : the loader; drives byte_ready, im_*, cpu_run, busy, done
interface prog_loader_if;
    logic        start;
    logic [7:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;
    logic        cpu_run;
    logic        busy;
    logic        done;

    modport master (
        output start, word_count, byte_in, byte_valid,
        input  byte_ready, im_we, im_addr, im_wdata, cpu_run, busy, done
    );

    modport slave (
        input  start, word_count, byte_in, byte_valid,
        output byte_ready, im_we, im_addr, im_wdata, cpu_run, busy, done
    );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader. Assembles big-endian 16-bit words from a byte
// stream, writes them to instruction memory at consecutive even addresses
// from 0x0000, then enables the CPU pipeline.
//   clk : system clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : prog_loader_if.slave (request, byte stream, IM write port, status)
// All outputs are registered copies of next-state decodes (Moore).
module prog_loader (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StHi, StLo, StWrite, StRun} state_e;

    state_e      state_q, state_d;
    logic [7:0]  remaining_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [7:0]  wd_hi_q;      // high byte frozen for the word being written
    logic [15:0] im_addr_q;
    logic        byte_ready_q;
    logic        im_we_q;
    logic        cpu_run_q;
    logic        busy_q;
    logic        done_q;
    logic        xfer;

    // byte_ready_q is high exactly in HI and LO, so this is the handshake.
    assign xfer = bus.byte_valid & byte_ready_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun: begin
                if (bus.start) begin
                    state_d = (bus.word_count == 8'd0) ? StRun : StHi;
                end
            end
            StHi:    if (xfer) state_d = StLo;
            StLo:    if (xfer) state_d = StWrite;
            StWrite: state_d = (remaining_q == 8'd1) ? StRun : StHi;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            remaining_q  <= 8'd0;
            hi_q         <= 8'd0;
            lo_q         <= 8'd0;
            wd_hi_q      <= 8'd0;
            im_addr_q    <= 16'd0;
            byte_ready_q <= 1'b0;
            im_we_q      <= 1'b0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= (state_d == StHi) || (state_d == StLo);
            im_we_q      <= (state_d == StWrite);
            cpu_run_q    <= (state_d == StRun);
            busy_q       <= (state_d == StHi) || (state_d == StLo) || (state_d == StWrite);
            // A zero-word restart from RUN re-enters RUN and pulses done again.
            done_q       <= (state_d == StRun) && ((state_q != StRun) || bus.start);

            unique case (state_q)
                StIdle, StRun: begin
                    if (bus.start && (bus.word_count != 8'd0)) begin
                        im_addr_q   <= 16'd0;
                        remaining_q <= bus.word_count;
                    end
                end
                StHi: begin
                    if (xfer) hi_q <= bus.byte_in;
                end
                StLo: begin
                    if (xfer) begin
                        lo_q    <= bus.byte_in;
                        wd_hi_q <= hi_q;
                    end
                end
                StWrite: begin
                    im_addr_q   <= im_addr_q + 16'd2;
                    remaining_q <= remaining_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.im_we      = im_we_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.im_wdata   = {wd_hi_q, lo_q};
    assign bus.cpu_run    = cpu_run_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized
// loads checked against a queue model of expected {address, word} writes.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if bus ();

    prog_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  load_bytes[$];
    logic [7:0]  tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];
    int          done_cnt = 0;

    // Observed memory writes and done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.im_we) wr_q.push_back({bus.im_addr, bus.im_wdata});
            if (bus.done) done_cnt++;
        end
    end

    // Reference: word i is {byte 2i, byte 2i+1} written at address 2*i.
    task automatic build_model();
        exp_q.delete();
        for (int i = 0; i < load_bytes.size() / 2; i++) begin
            exp_q.push_back({16'(2 * i), load_bytes[2 * i], load_bytes[2 * i + 1]});
        end
        tx_q = load_bytes;
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic prep_random(input int words);
        load_bytes.delete();
        for (int i = 0; i < 2 * words; i++) load_bytes.push_back(8'($urandom));
        build_model();
    endtask

    function automatic int count_diff();
        int n;
        n = (wr_q.size() > exp_q.size()) ? wr_q.size() - exp_q.size()
                                         : exp_q.size() - wr_q.size();
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            if (wr_q[i] !== exp_q[i]) n++;
        end
        return n;
    endfunction

    task automatic do_start(input logic [7:0] wc);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.word_count = wc;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.word_count = 8'($urandom);
    endtask

    // Feeds tx_q; returns at the negedge after the last byte is accepted.
    task automatic push_stream(input int gap_pct, input bit alt, output bit ok);
        int cyc = 0;
        bit ph  = 1'b1;
        while (tx_q.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            bus.byte_valid = alt ? ph : ($urandom_range(99) >= gap_pct);
            ph = ~ph;
            bus.byte_in = bus.byte_valid ? tx_q[0] : 8'($urandom);
            if (bus.byte_valid && bus.byte_ready) void'(tx_q.pop_front());
            cyc++;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom);
        ok = (tx_q.size() == 0);
    endtask

    function automatic logic [36:0] outs();
        return {bus.byte_ready, bus.im_we, bus.im_addr, bus.im_wdata,
                bus.cpu_run, bus.busy, bus.done};
    endfunction

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 37'd0) begin
            errors++; $display("FAIL reset_values: got %h expected 0", outs());
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_in    = 8'($urandom);
        end
        bus.byte_valid = 1'b0;
        #1;
        checks++;
        if ({bus.cpu_run, bus.busy, bus.byte_ready, bus.im_we} !== 4'b0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got run=%b busy=%b rdy=%b writes=%0d expected 0",
                     bus.cpu_run, bus.busy, bus.byte_ready, wr_q.size());
        end
        // Asynchronous reset from RUN with non-zero outputs.
        load_bytes = '{8'hA5, 8'h5A};
        build_model();
        do_start(8'd1);
        push_stream(0, 1'b0, ok);
        @(negedge clk);
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.im_wdata !== 16'hA55A) begin
            errors++;
            $display("FAIL pre_async_reset: got run=%b wdata=%h expected 1/a55a",
                     bus.cpu_run, bus.im_wdata);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== 37'd0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        prep_random(0);
        do_start(8'd0);
        checks++;
        if ({bus.done, bus.cpu_run, bus.busy} !== 3'b110) begin
            errors++;
            $display("FAIL zero_enter_run: got done/run/busy=%b expected 110",
                     {bus.done, bus.cpu_run, bus.busy});
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_run !== 1'b1 || wr_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL zero_after: got done=%b run=%b writes=%0d dones=%0d expected 0/1/0/1",
                     bus.done, bus.cpu_run, wr_q.size(), done_cnt);
        end
    endtask

    task automatic test_basic();
        bit ok;
        load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        build_model();
        do_start(8'd2);
        push_stream(0, 1'b0, ok);
        checks++;
        if (!ok || bus.im_we !== 1'b1 || bus.im_addr !== 16'h0002 || bus.im_wdata !== 16'h5678) begin
            errors++;
            $display("FAIL basic_last_write: got ok=%b we=%b addr=%h data=%h expected 1/1/0002/5678",
                     ok, bus.im_we, bus.im_addr, bus.im_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.cpu_run !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got run=%b done=%b busy=%b expected 1/1/0",
                     bus.cpu_run, bus.done, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cpu_run !== 1'b1 || bus.im_we !== 1'b0 ||
            bus.im_addr !== 16'h0004 || bus.im_wdata !== 16'h5678) begin
            errors++;
            $display("FAIL basic_hold: got done=%b run=%b we=%b addr=%h data=%h expected 0/1/0/0004/5678",
                     bus.done, bus.cpu_run, bus.im_we, bus.im_addr, bus.im_wdata);
        end
        #1;
        checks++;
        if (count_diff() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL basic_writes: got %0d diffs %0d dones expected 0 diffs 1 done",
                     count_diff(), done_cnt);
        end
    endtask

    task automatic test_gapped();
        bit ok;
        load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        build_model();
        do_start(8'd2);
        repeat (3) begin
            @(negedge clk);
            bus.byte_in    = 8'h12;
            bus.byte_valid = 1'b0;
        end
        push_stream(0, 1'b1, ok);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || count_diff() != 0 || done_cnt != 1 || bus.cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL gapped_writes: got ok=%b diffs=%0d dones=%0d run=%b expected 1/0/1/1",
                     ok, count_diff(), done_cnt, bus.cpu_run);
        end
    endtask

    task automatic test_reset_midload();
        bit ok;
        bit seen;
        prep_random(4);
        do_start(8'd4);
        while (tx_q.size() > 3) void'(tx_q.pop_back());
        push_stream(0, 1'b0, ok);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bus.byte_valid = 1'b1;
            bus.byte_in    = 8'($urandom);
            if (bus.byte_ready || bus.busy || bus.cpu_run) seen = 1'b1;
        end
        bus.byte_valid = 1'b0;
        #1;
        checks++;
        if (!ok || seen || count_diff() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL midload_abort: got ok=%b active=%b diffs=%0d dones=%0d expected 1/0/0/0",
                     ok, seen, count_diff(), done_cnt);
        end
        load_bytes = '{8'hAB, 8'hCD};
        build_model();
        do_start(8'd1);
        push_stream(0, 1'b0, ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || count_diff() != 0 || bus.cpu_run !== 1'b1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL midload_restart: got ok=%b diffs=%0d run=%b done=%b expected 1/0/1/1",
                     ok, count_diff(), bus.cpu_run, bus.done);
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        prep_random(2);
        do_start(8'd2);
        @(negedge clk);
        bus.byte_in    = tx_q[0];
        bus.byte_valid = 1'b1;
        if (bus.byte_ready) void'(tx_q.pop_front());
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b1;
        bus.word_count = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.byte_ready !== 1'b1 || bus.cpu_run !== 1'b0 || tx_q.size() != 3) begin
            errors++;
            $display("FAIL start_in_lo: got busy=%b rdy=%b run=%b left=%0d expected 1/1/0/3",
                     bus.busy, bus.byte_ready, bus.cpu_run, tx_q.size());
        end
        push_stream(30, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || count_diff() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL start_ignored_writes: got ok=%b diffs=%0d dones=%0d expected 1/0/1",
                     ok, count_diff(), done_cnt);
        end
        prep_random(1);
        do_start(8'd1);
        checks++;
        if (bus.cpu_run !== 1'b0 || bus.busy !== 1'b1 || bus.im_addr !== 16'h0000) begin
            errors++;
            $display("FAIL restart_from_run: got run=%b busy=%b addr=%h expected 0/1/0000",
                     bus.cpu_run, bus.busy, bus.im_addr);
        end
        push_stream(0, 1'b0, ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || count_diff() != 0 || bus.cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL restart_writes: got ok=%b diffs=%0d run=%b expected 1/0/1",
                     ok, count_diff(), bus.cpu_run);
        end
    endtask

    task automatic test_random();
        bit ok;
        int wc;
        for (int it = 0; it < 20; it++) begin
            wc = ($urandom_range(4) == 0) ? 0 : $urandom_range(12, 1);
            prep_random(wc);
            do_start(8'(wc));
            checks++;
            if (wc == 0) begin
                if (bus.done !== 1'b1 || bus.cpu_run !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_zero it=%0d: got done=%b run=%b expected 1/1",
                             it, bus.done, bus.cpu_run);
                end
            end else begin
                if (bus.busy !== 1'b1 || bus.cpu_run !== 1'b0 || bus.im_addr !== 16'h0000) begin
                    errors++;
                    $display("FAIL rand_start it=%0d: got busy=%b run=%b addr=%h expected 1/0/0000",
                             it, bus.busy, bus.cpu_run, bus.im_addr);
                end
                push_stream($urandom_range(60), 1'b0, ok);
                checks++;
                if (!ok || bus.im_we !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_last_write it=%0d: got ok=%b we=%b expected 1/1",
                             it, ok, bus.im_we);
                end
                @(negedge clk);
            end
            @(negedge clk);
            #1;
            checks++;
            if (count_diff() != 0 || done_cnt != 1 || bus.done !== 1'b0 || bus.cpu_run !== 1'b1) begin
                errors++;
                $display("FAIL rand_load it=%0d wc=%0d: got diffs=%0d dones=%0d done=%b run=%b expected 0/1/0/1",
                         it, wc, count_diff(), done_cnt, bus.done, bus.cpu_run);
            end
        end
    endtask

    task automatic test_max();
        bit ok;
        prep_random(255);
        do_start(8'd255);
        push_stream(0, 1'b0, ok);
        checks++;
        if (!ok || bus.im_we !== 1'b1 || bus.im_addr !== 16'h01FC) begin
            errors++;
            $display("FAIL max_last_addr: got ok=%b we=%b addr=%h expected 1/1/01fc",
                     ok, bus.im_we, bus.im_addr);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (count_diff() != 0 || wr_q.size() != 255 || done_cnt != 1) begin
            errors++;
            $display("FAIL max_writes: got diffs=%0d writes=%0d dones=%0d expected 0/255/1",
                     count_diff(), wr_q.size(), done_cnt);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = 8'd0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        test_reset();
        test_zero();
        test_basic();
        test_gapped();
        test_reset_midload();
        test_start_ignored();
        test_random();
        test_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset; forces reset state immediately, independent of clk.
REQ-003: start  input  1  load request, sampled each edge.
REQ-004: word_count  input  8  number of 16-bit instruction words to load (0-255), sampled with start.
REQ-005: byte_in  input  8  serial program byte stream.
REQ-006: byte_valid  input  1  byte_in holds a valid byte.
REQ-007: byte_ready  output  1  loader accepts byte this cycle.
REQ-008: im_we  output  1  instruction-memory write strobe.
REQ-009: im_addr  output  16  instruction-memory byte address, even-aligned.
REQ-010: im_wdata  output  16  instruction word to write.
REQ-011: cpu_run  output  1  pipeline enable; drives the CPU w_enable input.
REQ-012: busy  output  1  high while a load is in progress.
REQ-013: done  output  1  one-cycle pulse on load completion.

Function
REQ-014: FSM states SHALL be IDLE, HI, LO, WRITE, RUN; all outputs registered or decoded from state only (Moore).
REQ-015: Byte transfer SHALL occur at a rising edge where byte_valid=1 and byte_ready=1; byte_ready=1 only in HI and LO.
REQ-016: IDLE, start=1, word_count!=0 -> HI; im_addr<=0x0000; remaining<=word_count.
REQ-017: IDLE, start=1, word_count=0 -> RUN directly, with no write; done pulses in the cycle RUN is entered.
REQ-018: HI: on transfer, high byte register<=byte_in, -> LO; without transfer, remain.
REQ-019: LO: on transfer, low byte register<=byte_in, -> WRITE; without transfer, remain.
REQ-020: WRITE SHALL last exactly one cycle, with im_we=1, im_wdata={high byte, low byte} (big-endian), im_addr=current address.
REQ-021: Leaving WRITE: im_addr<=im_addr+2 (16-bit, modulo 2^16); remaining<=remaining-1; -> RUN if remaining was 1, else -> HI.
REQ-022: done SHALL be 1 for exactly the first cycle in RUN; cpu_run=1 in every RUN cycle, 0 in all other states.
REQ-023: busy=1 in HI, LO, WRITE; 0 in IDLE and RUN.
REQ-024: start SHALL be ignored in HI, LO, WRITE.
REQ-025: start=1 in RUN SHALL restart the load per REQ-016/017: cpu_run=0 from the next cycle when word_count!=0, im_addr<=0x0000.
REQ-026: Bytes presented while byte_ready=0 SHALL NOT be consumed or latched.
REQ-027: im_we=0 outside WRITE; im_wdata and im_addr hold their last values when im_we=0.
REQ-028: Maximum load of 255 words SHALL end with the last write at 0x01FC, with no address wrap.
REQ-029: Latency: last byte accepted at edge k -> im_we high in cycle k..k+1 -> cpu_run and done high after edge k+1.

Reset
REQ-030: rst=1 SHALL force state IDLE, byte_ready=0, im_we=0, im_addr=0x0000, im_wdata=0x0000, cpu_run=0, busy=0, done=0, remaining=0, byte registers=0x00.
REQ-031: Reset mid-load SHALL abort with no further im_we pulse; after rst=0, a new start is required.
REQ-032: After rst deasserts, the loader SHALL stay in IDLE with cpu_run=0 until start.

Verification
REQ-033: Reset asserted asynchronously between edges -> all outputs at REQ-030 values before the next edge.
REQ-034: start, word_count=2, bytes 0x12,0x34,0x56,0x78 back-to-back -> writes 0x1234@0x0000 and 0x5678@0x0002 -> done pulse, cpu_run=1.
REQ-035: Same load with byte_valid toggling 1-0-1-0 and 0x12 held 3 cycles before valid -> identical writes, no extra im_we, no duplicate bytes.
REQ-036: start, word_count=0 -> RUN next cycle, done=1 for one cycle, im_we never asserted.
REQ-037: rst pulsed after 3 bytes of a 4-word load -> IDLE, no write for the partial word; restart with 1 word 0xABCD -> write 0xABCD@0x0000.
REQ-038: start pulsed during LO, then start in RUN with word_count=1 -> first start ignored; second start drops cpu_run and reloads at 0x0000.
